// File: rtl/regfile_wr.sv
// Write side of a register file: one-hot decoded write port, hard-wired zero register
// at the top index, and a multi-cycle clear sequencer that locks out writes while it runs.
`timescale 1ns/1ps

module regfile_wr #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(NREG)-1:0]       wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          clr_req,
    output logic [DATA_W-1:0]             regs_out [NREG-1:0],
    output logic                          busy,
    output logic                          wr_ack,
    output logic                          wr_drop,
    output logic                          clr_done
);

    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned NSTOR = NREG - 1;
    localparam logic [AW-1:0] LAST_CLR = AW'(NREG - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic              r_busy;
    logic              r_wr_ack;
    logic              r_wr_drop;
    logic              r_clr_done;
    logic              w_clr_active;
    logic              w_in_done;
    logic              w_wr_ok;
    logic [NSTOR-1:0]  w_wr_dec;
    logic [NSTOR-1:0]  w_wr_sel;
    logic [NSTOR-1:0]  w_clr_sel;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr_req outside IDLE is simply not looked at
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_cnt == LAST_CLR) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_clr_active = 1'b0;
        w_in_done    = 1'b0;
        case (r_state)
            S_CLEAR: w_clr_active = 1'b1;
            S_DONE:  w_in_done    = 1'b1;
            default: ;
        endcase
    end

    // Clear index: zero on entry to CLEAR, advances once per CLEAR cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_active) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // Index NREG-1 shifts out of the storage-wide one-hot, so the zero register gets no enable
    assign w_wr_ok   = wr_en & ~r_busy;
    assign w_wr_dec  = NSTOR'(1) << wr_addr;
    assign w_wr_sel  = w_wr_ok ? w_wr_dec : '0;
    assign w_clr_sel = w_clr_active ? (NSTOR'(1) << r_clr_cnt) : '0;

    // Status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt != S_IDLE);
            r_wr_ack   <= w_wr_ok;
            r_wr_drop  <= wr_en & r_busy;
            r_clr_done <= w_in_done;
        end
    end

    assign busy     = r_busy;
    assign wr_ack   = r_wr_ack;
    assign wr_drop  = r_wr_drop;
    assign clr_done = r_clr_done;

    for (genvar g = 0; g < NSTOR; g++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_clr_sel[g]) begin
                r_q <= '0;
            end else if (w_wr_sel[g]) begin
                r_q <= wr_data;
            end
        end

        assign regs_out[g] = r_q;
    end

    assign regs_out[NREG-1] = '0;

endmodule

// File: tb/tb_regfile_wr.sv
// Directed bench for regfile_wr: writes, zero register, clear sequence, lockout and reset abort.
`timescale 1ns/1ps

module tb_regfile_wr;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        clr_req;
    logic [63:0] regs_out [31:0];
    logic        busy;
    logic        wr_ack;
    logic        wr_drop;
    logic        clr_done;

    int n_pass  = 0;
    int n_total = 0;

    regfile_wr #(.DATA_W(64), .NREG(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .regs_out (regs_out),
        .busy     (busy),
        .wr_ack   (wr_ack),
        .wr_drop  (wr_drop),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) if (regs_out[i] !== 64'd0) bad++;
        if (bad !== 0) $display("FAIL reset_regs: nonzero=%0d want 0", bad); else n_pass++;
        n_total++;
        if ({busy, wr_ack, wr_drop, clr_done} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy, wr_ack, wr_drop, clr_done});
        else n_pass++;
        n_total++;
    endtask

    // rst_n released just after an edge; the very next edge must accept the write
    task automatic test_write_x5();
        int bad;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0123_4567_89AB_CDEF;
        tick();
        wr_en = 1'b0;
        if (regs_out[5] !== 64'h0123_4567_89AB_CDEF)
            $display("FAIL x5_value: got %h want 0123456789abcdef", regs_out[5]);
        else n_pass++;
        n_total++;
        if ({wr_ack, wr_drop} !== 2'b10)
            $display("FAIL x5_ack: got ack/drop %b want 10", {wr_ack, wr_drop});
        else n_pass++;
        n_total++;
        bad = 0;
        for (int i = 0; i < 32; i++) if (i != 5 && regs_out[i] !== 64'd0) bad++;
        if (bad !== 0) $display("FAIL x5_others: nonzero=%0d want 0", bad); else n_pass++;
        n_total++;
        tick();
        if ({wr_ack, wr_drop} !== 2'b00)
            $display("FAIL idle_no_ack: got ack/drop %b want 00", {wr_ack, wr_drop});
        else n_pass++;
        n_total++;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wr_en = 1'b0;
        if (regs_out[31] !== 64'd0) $display("FAIL x31_zero: got %h want 0", regs_out[31]); else n_pass++;
        n_total++;
        if (wr_ack !== 1'b1) $display("FAIL x31_ack: got %b want 1", wr_ack); else n_pass++;
        n_total++;
        if (regs_out[5] !== 64'h0123_4567_89AB_CDEF)
            $display("FAIL x31_side: x5 got %h want 0123456789abcdef", regs_out[5]);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_clear();
        int nack, bad, busy_cnt, x30_at, done_cnt, done_at;
        logic [63:0] x0_k1, x30_k30;
        nack = 0;
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i + 1);
            tick();
            if (wr_ack !== 1'b1) nack++;
        end
        wr_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 31; i++) if (regs_out[i] !== 64'(i + 1)) bad++;
        if (nack !== 0 || bad !== 0) $display("FAIL fill: nack=%0d badval=%0d want 0 0", nack, bad); else n_pass++;
        n_total++;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        x30_at = -1; done_cnt = 0; done_at = -1; x0_k1 = '1; x30_k30 = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (k == 1) x0_k1 = regs_out[0];
            if (k == 30) x30_k30 = regs_out[30];
            if (x30_at < 0 && regs_out[30] === 64'd0) x30_at = k;
            if (clr_done === 1'b1) begin done_cnt++; done_at = k; end
        end
        if (busy_cnt !== 32) $display("FAIL clr_busy_len: got %0d want 32", busy_cnt); else n_pass++;
        n_total++;
        if (x0_k1 !== 64'd0) $display("FAIL clr_x0: got %h want 0", x0_k1); else n_pass++;
        n_total++;
        if (x30_k30 !== 64'd31 || x30_at !== 31)
            $display("FAIL clr_x30: k30=%0d zero_at=%0d want 31 31", x30_k30, x30_at);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1 || done_at !== 32)
            $display("FAIL clr_done: cnt=%0d at=%0d want 1 32", done_cnt, done_at);
        else n_pass++;
        n_total++;
        bad = 0;
        for (int i = 0; i < 32; i++) if (regs_out[i] !== 64'd0) bad++;
        if (bad !== 0 || busy !== 1'b0) $display("FAIL clr_end: nonzero=%0d busy=%b want 0 0", bad, busy); else n_pass++;
        n_total++;
    endtask

    // Write plus a repeated clr_req at clear index 10: the write drops, the clear does not restart
    task automatic test_drop_during_clear();
        int busy_cnt, done_cnt, acks;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        repeat (10) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hAA; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        if (busy === 1'b1) busy_cnt++;
        if ({wr_ack, wr_drop} !== 2'b01)
            $display("FAIL drop_pulse: got ack/drop %b want 01", {wr_ack, wr_drop});
        else n_pass++;
        n_total++;
        tick();
        if (busy === 1'b1) busy_cnt++;
        if ({wr_ack, wr_drop} !== 2'b00)
            $display("FAIL drop_clears: got ack/drop %b want 00", {wr_ack, wr_drop});
        else n_pass++;
        n_total++;
        done_cnt = 0; acks = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            if (wr_ack === 1'b1) acks++;
        end
        if (busy_cnt !== 32 || done_cnt !== 1)
            $display("FAIL drop_norestart: busy=%0d done=%0d want 32 1", busy_cnt, done_cnt);
        else n_pass++;
        n_total++;
        if (regs_out[7] !== 64'd0 || acks !== 0)
            $display("FAIL drop_x7: x7=%h acks=%0d want 0 0", regs_out[7], acks);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_write_with_clear();
        int done_cnt;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        if ({wr_ack, busy, regs_out[3]} !== {2'b11, 64'h55})
            $display("FAIL wc_accept: ack=%b busy=%b x3=%h want 1 1 55", wr_ack, busy, regs_out[3]);
        else n_pass++;
        n_total++;
        repeat (3) tick();
        if (regs_out[3] !== 64'h55) $display("FAIL wc_hold: got %h want 55", regs_out[3]); else n_pass++;
        n_total++;
        tick();
        if (regs_out[3] !== 64'd0) $display("FAIL wc_zeroed: got %h want 0", regs_out[3]); else n_pass++;
        n_total++;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (clr_done === 1'b1) done_cnt++;
        end
        if (done_cnt !== 1 || busy !== 1'b0)
            $display("FAIL wc_done: done=%0d busy=%b want 1 0", done_cnt, busy);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_clear();
        int bad, busy_cnt, done_cnt;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h99;
        tick();
        wr_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (15) tick();
        if (regs_out[20] !== 64'h99 || busy !== 1'b1)
            $display("FAIL rst_pre: x20=%h busy=%b want 99 1", regs_out[20], busy);
        else n_pass++;
        n_total++;
        #2 rst_n = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 32; i++) if (regs_out[i] !== 64'd0) bad++;
        if (bad !== 0 || busy !== 1'b0 || clr_done !== 1'b0)
            $display("FAIL rst_async: nonzero=%0d busy=%b done=%b want 0 0 0", bad, busy, clr_done);
        else n_pass++;
        n_total++;
        tick();
        rst_n = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
        end
        if (busy_cnt !== 0 || done_cnt !== 0)
            $display("FAIL rst_abort: busy=%0d done=%0d want 0 0", busy_cnt, done_cnt);
        else n_pass++;
        n_total++;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h1234;
        tick();
        wr_en = 1'b0;
        if (wr_ack !== 1'b1 || regs_out[9] !== 64'h1234)
            $display("FAIL rst_write: ack=%b x9=%h want 1 1234", wr_ack, regs_out[9]);
        else n_pass++;
        n_total++;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
        repeat (3) tick();
        test_reset();
        test_write_x5();
        test_zero_reg();
        test_clear();
        test_drop_during_clear();
        test_write_with_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
